sad_min_tracker: RTL and testbench
==================================

Name: sad_min_tracker

Overview:
- Downstream consumer of the 4x4 SAD processing element. Receives one 12-bit SAD per candidate displacement, in raster order over a full-search window.
- Tracks the minimum SAD and the displacement (motion vector) that produced it.
- Reports the winning vector with a one-cycle done pulse at the end of each block search.
- Sits between the PE array output and the motion-vector writeback logic.

Parameters:
- SAD_W, 12, width of incoming SAD and of best_sad.
- RANGE, 4, search range p. The window is mv in [-p, +p] on each axis, so (2p+1)^2 = 81 positions.
- MV_W, 4, signed width of each mv component. Must hold -RANGE..+RANGE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a new block search. Accepted in IDLE only.
- sad_valid  in  1  sad carries a valid candidate this cycle.
- sad  in  SAD_W  SAD for the current raster position, unsigned.
- busy  out  1  high in SEARCH and REPORT.
- done  out  1  one-cycle pulse; results valid from this cycle.
- best_sad  out  SAD_W  minimum SAD of the last completed search.
- best_mv_x  out  MV_W  signed x displacement of the minimum.
- best_mv_y  out  MV_W  signed y displacement of the minimum.
- pos_cnt  out  7  number of candidates accepted in the current search (debug).

Behaviour:
- Reset is asynchronous and active-low on rst_n; there is one clock, clk.
- Reset values: state=IDLE, busy=0, done=0, best_sad=all ones (4095), best_mv_x=0, best_mv_y=0, pos_cnt=0. Internal cur_x and cur_y reset to -RANGE.
- States are IDLE, SEARCH and REPORT.
- IDLE:
  - start=1 -> SEARCH.
  - On entering SEARCH: cur_x=cur_y=-RANGE, pos_cnt=0, first flag set.
  - sad_valid is ignored in IDLE.
- SEARCH, on each cycle with sad_valid=1:
  - If first flag is set, or sad < best_sad (strict): best_sad<=sad, best_mv_x<=cur_x, best_mv_y<=cur_y.
  - Clear the first flag and increment pos_cnt.
  - Advance the raster counter: cur_x++. When cur_x=+RANGE, wrap cur_x to -RANGE and increment cur_y.
  - Ties keep the earliest candidate in raster order (y outer, x inner).
- Cycles with sad_valid=0 in SEARCH are stalls: no state change, counters hold.
- Last candidate: when the accepted sample is at cur_x=cur_y=+RANGE (pos_cnt reaches 81), go to REPORT on that same edge. The best_* update from that final sample lands on the same edge.
- REPORT lasts exactly one cycle: done=1, busy=1. The next state is IDLE unconditionally.
- start and sad_valid in SEARCH and REPORT are ignored.
- Latency: done rises one clock after the final sad_valid cycle.
- best_* outputs hold their values from REPORT until the next search's first accepted sample overwrites them.
- Width rules:
  - The SAD comparison is unsigned, full SAD_W bits.
  - mv components are two's complement MV_W bits.
  - The counter never exceeds +RANGE, so there is no overflow.
- Reset mid-search: all state returns to the reset values immediately (asynchronous). The partial search is discarded and no done pulse is issued.
- start held high continuously is legal. A new search begins in the IDLE cycle following REPORT.

Decomposition:
- Package fsbm_pkg holds:
  - SAD_W and RANGE defaults;
  - MV_W, derived as clog2(RANGE+1)+1;
  - NUM_POS = (2*RANGE+1)^2;
  - state enum {IDLE, SEARCH, REPORT}.
- Sub-module mv_raster_counter: signed cur_x/cur_y generator. Its ports are clear, advance, cur_x, cur_y and last, where last is combinational and high when cur_x=cur_y=+RANGE.
- The comparator, best registers and FSM stay in the top module.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> all outputs at reset values asynchronously (best_sad=4095, done=0, busy=0).
- Single minimum: feed 81 SADs = 500, except index 40 (mv 0,0) = 17 -> done one clock after the 81st valid; best_sad=17, mv=(0,0).
- Tie and corner: all SADs = 4095 -> best_sad=4095, mv=(-4,-4). Then index 80 = 3 and index 2 = 3 -> mv=(-2,-4), earliest tie kept.
- Stalls: same stream as the single-minimum case with sad_valid deasserted randomly 30% of cycles -> identical result. done is single-cycle, and pos_cnt=81 at done.
- Ignored inputs: pulse start and sad_valid in IDLE, and start during SEARCH -> no effect; pos_cnt counts only valid samples in SEARCH.
- Reset mid-search: rst_n low after 50 samples, then start a new 81-sample search with minimum 9 at mv (+4,+4) -> single done; best_sad=9, mv=(4,4).

Source files
------------

// File: rtl/fsbm_pkg.sv
// Shared parameters and state encoding for the full-search block-matching minimum tracker.
package fsbm_pkg;

    localparam int DEF_SAD_W = 12;
    localparam int DEF_RANGE = 4;
    localparam int DEF_MV_W  = $clog2(DEF_RANGE + 1) + 1;
    localparam int NUM_POS   = (2 * DEF_RANGE + 1) * (2 * DEF_RANGE + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/sad_min_tracker_if.sv
// Candidate SAD stream in, best-match result out.
interface sad_min_tracker_if
    import fsbm_pkg::*;
#(
    parameter int SAD_W = DEF_SAD_W,
    parameter int MV_W  = DEF_MV_W
);

    logic                    start;
    logic                    sad_valid;
    logic [SAD_W-1:0]        sad;
    logic                    busy;
    logic                    done;
    logic [SAD_W-1:0]        best_sad;
    logic signed [MV_W-1:0]  best_mv_x;
    logic signed [MV_W-1:0]  best_mv_y;
    logic [6:0]              pos_cnt;

    modport master (
        output start, sad_valid, sad,
        input  busy, done, best_sad, best_mv_x, best_mv_y, pos_cnt
    );

    modport slave (
        input  start, sad_valid, sad,
        output busy, done, best_sad, best_mv_x, best_mv_y, pos_cnt
    );

endinterface

// File: rtl/mv_raster_counter.sv
// Signed raster walk over [-RNG, +RNG]^2, x inner and y outer; last flags the final position.
module mv_raster_counter
    import fsbm_pkg::*;
#(
    parameter int RNG = DEF_RANGE,
    parameter int W   = DEF_MV_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                advance,
    output logic signed [W-1:0] cur_x,
    output logic signed [W-1:0] cur_y,
    output logic                last
);

    localparam logic signed [W-1:0] MV_MAX = W'(RNG);
    localparam logic signed [W-1:0] MV_MIN = W'(-RNG);
    localparam logic signed [W-1:0] MV_ONE = W'(1);

    assign last = (cur_x == MV_MAX) && (cur_y == MV_MAX);

    // Advancing past the final position folds back to the start so y never leaves the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x <= MV_MIN;
            cur_y <= MV_MIN;
        end else if (clear) begin
            cur_x <= MV_MIN;
            cur_y <= MV_MIN;
        end else if (advance) begin
            if (cur_x == MV_MAX) begin
                cur_x <= MV_MIN;
                cur_y <= last ? MV_MIN : cur_y + MV_ONE;
            end else begin
                cur_x <= cur_x + MV_ONE;
            end
        end
    end

endmodule

// File: rtl/sad_min_tracker.sv
// Tracks the minimum SAD over a full-search window and reports its motion vector.
// state  | meaning
// IDLE   | waiting for start, results of last search held
// SEARCH | accepting one SAD per sad_valid cycle in raster order
// REPORT | single-cycle done pulse, results valid
module sad_min_tracker
    import fsbm_pkg::*;
#(
    parameter int SAD_W = DEF_SAD_W,
    parameter int RANGE = DEF_RANGE,
    parameter int MV_W  = DEF_MV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    sad_min_tracker_if.slave bus
);

    state_t                 state;
    logic                   first;
    logic                   busy_q;
    logic                   done_q;
    logic [SAD_W-1:0]       best_sad_q;
    logic signed [MV_W-1:0] best_mv_x_q;
    logic signed [MV_W-1:0] best_mv_y_q;
    logic [6:0]             pos_cnt_q;

    logic                   clear;
    logic                   advance;
    logic                   last;
    logic signed [MV_W-1:0] cur_x;
    logic signed [MV_W-1:0] cur_y;

    assign clear   = (state == IDLE) && bus.start;
    assign advance = (state == SEARCH) && bus.sad_valid;

    mv_raster_counter #(
        .RNG (RANGE),
        .W   (MV_W)
    ) u_raster (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .advance (advance),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            first       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            best_sad_q  <= '1;
            best_mv_x_q <= '0;
            best_mv_y_q <= '0;
            pos_cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state     <= SEARCH;
                        busy_q    <= 1'b1;
                        first     <= 1'b1;
                        pos_cnt_q <= '0;
                    end
                end
                SEARCH: begin
                    if (bus.sad_valid) begin
                        // Strict compare keeps the earliest raster position on ties.
                        if (first || (bus.sad < best_sad_q)) begin
                            best_sad_q  <= bus.sad;
                            best_mv_x_q <= cur_x;
                            best_mv_y_q <= cur_y;
                        end
                        first     <= 1'b0;
                        pos_cnt_q <= pos_cnt_q + 7'd1;
                        if (last) begin
                            state  <= REPORT;
                            done_q <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.best_sad  = best_sad_q;
    assign bus.best_mv_x = best_mv_x_q;
    assign bus.best_mv_y = best_mv_y_q;
    assign bus.pos_cnt   = pos_cnt_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Directed bench for sad_min_tracker: expected results are queued by the stimulus and checked on done.
module tb_sad_min_tracker;
    import fsbm_pkg::*;

    typedef struct {
        int sad;
        int mx;
        int my;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sad_min_tracker_if bus ();

    sad_min_tracker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_done = 0;
    logic [11:0] vec [81];

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Monitor: every done pulse is matched against the oldest queued expectation.
    initial begin
        exp_t e;
        bit   prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                check("done_single_cycle", int'(prev_done), 0);
                check("done_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("best_sad", int'(bus.best_sad), e.sad);
                    check("best_mv_x", int'(bus.best_mv_x), e.mx);
                    check("best_mv_y", int'(bus.best_mv_y), e.my);
                    check("pos_cnt_at_done", int'(bus.pos_cnt), NUM_POS);
                    check("busy_at_done", int'(bus.busy), 1);
                end
            end
            prev_done = bus.done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill(input int val);
        for (int i = 0; i < 81; i++) vec[i] = 12'(val);
    endtask

    task automatic run_search(input int n, input int stall_pct, input bit hold_start);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = hold_start;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 6 && $urandom_range(99) < stall_pct; k++) begin
                bus.sad_valid = 1'b0;
                bus.sad = 12'($urandom);
                @(negedge clk);
            end
            bus.sad_valid = 1'b1;
            bus.sad = vec[i];
            if (i == n - 1) bus.start = 1'b0;
            @(negedge clk);
        end
        bus.sad_valid = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic full_search(input int stall_pct, input bit hold_start);
        run_search(81, stall_pct, hold_start);
        check("done_latency", int'(bus.done), 1);
        @(negedge clk);
        check("done_fall", int'(bus.done), 0);
        check("busy_after_report", int'(bus.busy), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.sad_valid = 1'b0;
        bus.sad = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_best_sad", int'(bus.best_sad), 4095);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_pos_cnt", int'(bus.pos_cnt), 0);
        check("rst_mv_x", int'(bus.best_mv_x), 0);
        check("rst_mv_y", int'(bus.best_mv_y), 0);
        rst_n = 1'b1;

        // Single minimum at the window centre.
        fill(500);
        vec[40] = 12'd17;
        sb.push_back('{17, 0, 0});
        full_search(0, 1'b0);

        // Asynchronous reset between edges clears the held result.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_best_sad", int'(bus.best_sad), 4095);
        check("async_rst_pos_cnt", int'(bus.pos_cnt), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-max window: first candidate wins.
        fill(4095);
        sb.push_back('{4095, -4, -4});
        full_search(0, 1'b0);

        // Tie at index 2 and index 80: earliest kept.
        fill(4095);
        vec[2] = 12'd3;
        vec[80] = 12'd3;
        sb.push_back('{3, -2, -4});
        full_search(0, 1'b0);

        // Single-minimum stream again with ~30% stall cycles.
        fill(500);
        vec[40] = 12'd17;
        sb.push_back('{17, 0, 0});
        full_search(30, 1'b0);

        // sad_valid in IDLE is ignored; results and count hold.
        @(negedge clk);
        bus.sad_valid = 1'b1;
        bus.sad = 12'd0;
        @(negedge clk);
        bus.sad_valid = 1'b0;
        @(negedge clk);
        check("idle_valid_busy", int'(bus.busy), 0);
        check("idle_valid_best_sad", int'(bus.best_sad), 17);
        check("idle_valid_pos_cnt", int'(bus.pos_cnt), 81);

        // start held through SEARCH is ignored.
        fill(200);
        vec[10] = 12'd5;
        sb.push_back('{5, -3, -3});
        full_search(0, 1'b1);

        // Partial search with stalls, then reset mid-search.
        fill(100);
        run_search(50, 30, 1'b0);
        check("partial_pos_cnt", int'(bus.pos_cnt), 50);
        check("partial_busy", int'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midsearch_rst_busy", int'(bus.busy), 0);
        check("midsearch_rst_pos_cnt", int'(bus.pos_cnt), 0);
        check("midsearch_rst_best_sad", int'(bus.best_sad), 4095);
        check("midsearch_rst_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        fill(100);
        vec[80] = 12'd9;
        sb.push_back('{9, 4, 4});
        full_search(0, 1'b0);

        repeat (4) @(negedge clk);
        check("done_count", n_done, 6);
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
